// File: rtl/serial_shift_reg_if.sv
// Control and data bundle of the serial shift register: master drives the i_* side,
// slave is the register. Inputs are sampled on the rising clock; outputs are registered state.
interface serial_shift_reg_if #(
   parameter int unsigned N = 8
);
   localparam int unsigned CW = $clog2(N);

   logic          i_clr;
   logic          i_load;
   logic [N-1:0]  i_par_in;
   logic          i_start;
   logic          i_shift_en;
   logic          i_ser_in;
   logic          o_ser_out;
   logic [N-1:0]  o_par_out;
   logic          o_busy;
   logic          o_done;
   logic [CW-1:0] o_cnt;

   modport master (
      output i_clr, i_load, i_par_in, i_start, i_shift_en, i_ser_in,
      input  o_ser_out, o_par_out, o_busy, o_done, o_cnt
   );

   modport slave (
      input  i_clr, i_load, i_par_in, i_start, i_shift_en, i_ser_in,
      output o_ser_out, o_par_out, o_busy, o_done, o_cnt
   );
endinterface

// File: rtl/serial_shift_reg.sv
// N-bit parallel-load / serial-shift register with bit counter; done pulses N+stalls+1 edges after start.
// i_shift_en=0 stalls the shift sequence in place; clear aborts without a done pulse.
module serial_shift_reg #(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   serial_shift_reg_if.slave  bus
);
   localparam int unsigned CW = $clog2(N);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  reg_q, reg_d, shifted;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_comb begin
      if (MSB_FIRST) begin
         shifted = {reg_q[N-2:0], bus.i_ser_in};
      end else begin
         shifted = {bus.i_ser_in, reg_q[N-1:1]};
      end
   end

   // Priority: clear, then load/start (IDLE only), then shift.
   always_comb begin
      state_d = state_q;
      reg_d   = reg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (bus.i_clr) begin
         reg_d   = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end else if (state_q == IDLE) begin
         if (bus.i_load) begin
            reg_d = bus.i_par_in;
         end
         if (bus.i_start) begin
            state_d = SHIFT;
            cnt_d   = '0;
         end
      end else if (bus.i_shift_en) begin
         reg_d = shifted;
         if (cnt_q == CW'(N - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         reg_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         reg_q   <= reg_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.o_ser_out = MSB_FIRST ? reg_q[N-1] : reg_q[0];
   assign bus.o_par_out = reg_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_done    = done_q;
   assign bus.o_cnt     = cnt_q;
endmodule

// File: tb/tb_serial_shift_reg.sv
// Bench for serial_shift_reg: an 8-bit LSB-first and a 12-bit MSB-first instance.
// Final register values are queued at start and checked whenever o_done pulses.
module tb_serial_shift_reg;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   serial_shift_reg_if #(.N(8))  b8();
   serial_shift_reg_if #(.N(12)) b12();

   serial_shift_reg #(.N(8),  .MSB_FIRST(1'b0)) u8  (.i_clk(i_clk), .i_rst(i_rst), .bus(b8));
   serial_shift_reg #(.N(12), .MSB_FIRST(1'b1)) u12 (.i_clk(i_clk), .i_rst(i_rst), .bus(b12));

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0]  q8[$];
   logic [11:0] q12[$];

   typedef struct {
      logic       clr, load, start, sh, sin;
      logic [7:0] par;
      logic       e_so, e_busy, e_done;
      logic [2:0] e_cnt;
      logic [7:0] e_par;
   } vec_t;
   vec_t tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_row(input int i, input logic clr, input logic load, input logic start,
                          input logic sh, input logic sin, input logic [7:0] par,
                          input logic so, input logic busy, input logic done,
                          input logic [2:0] cnt, input logic [7:0] epar);
      tbl[i].clr = clr;   tbl[i].load = load; tbl[i].start = start;
      tbl[i].sh = sh;     tbl[i].sin = sin;   tbl[i].par = par;
      tbl[i].e_so = so;   tbl[i].e_busy = busy; tbl[i].e_done = done;
      tbl[i].e_cnt = cnt; tbl[i].e_par = epar;
   endtask

   task automatic run8(input logic sin, input int max, output int cyc);
      cyc = 0;
      b8.i_shift_en = 1'b1;
      b8.i_ser_in   = sin;
      while (b8.o_done !== 1'b1 && cyc < max) begin
         tick();
         cyc++;
      end
      b8.i_shift_en = 1'b0;
      check("done8_seen", b8.o_done, 1);
   endtask

   // Scoreboard: every done pulse must match a queued final value.
   always @(negedge i_clk) begin
      if (!i_rst && b8.o_done === 1'b1) begin
         if (q8.size() == 0) check("unexpected_done8", b8.o_done, 0);
         else check("final8", b8.o_par_out, q8.pop_front());
      end
      if (!i_rst && b12.o_done === 1'b1) begin
         if (q12.size() == 0) check("unexpected_done12", b12.o_done, 0);
         else check("final12", b12.o_par_out, q12.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      b8.i_clr = 0;  b8.i_load = 0;  b8.i_par_in = '0;  b8.i_start = 0;  b8.i_shift_en = 0;  b8.i_ser_in = 0;
      b12.i_clr = 0; b12.i_load = 0; b12.i_par_in = '0; b12.i_start = 0; b12.i_shift_en = 0; b12.i_ser_in = 0;

      set_row(0,  0,1,0,0,0, 8'hB4,  0,0,0, 3'd0, 8'hB4);
      set_row(1,  0,0,1,0,0, 8'h00,  0,1,0, 3'd0, 8'hB4);
      set_row(2,  0,0,0,1,0, 8'h00,  0,1,0, 3'd1, 8'h5A);
      set_row(3,  0,0,0,1,0, 8'h00,  1,1,0, 3'd2, 8'h2D);
      set_row(4,  0,0,0,1,1, 8'h00,  0,1,0, 3'd3, 8'h96);
      set_row(5,  0,0,0,1,1, 8'h00,  1,1,0, 3'd4, 8'hCB);
      set_row(6,  0,0,0,1,1, 8'h00,  1,1,0, 3'd5, 8'hE5);
      set_row(7,  0,0,0,1,1, 8'h00,  0,1,0, 3'd6, 8'hF2);
      set_row(8,  0,0,0,1,0, 8'h00,  1,1,0, 3'd7, 8'h79);
      set_row(9,  0,0,0,1,0, 8'h00,  0,0,1, 3'd0, 8'h3C);
      set_row(10, 0,0,0,0,0, 8'h00,  0,0,0, 3'd0, 8'h3C);

      #12;
      check("rst_par8",  b8.o_par_out, 0);
      check("rst_busy8", b8.o_busy, 0);
      check("rst_done8", b8.o_done, 0);
      check("rst_cnt8",  b8.o_cnt, 0);
      check("rst_so8",   b8.o_ser_out, 0);
      check("rst_par12", b12.o_par_out, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      tick();

      // LSB-first, load B4, shift in 3C.
      q8.push_back(8'h3C);
      for (int i = 0; i < 11; i++) begin
         b8.i_clr = tbl[i].clr;  b8.i_load = tbl[i].load; b8.i_start = tbl[i].start;
         b8.i_shift_en = tbl[i].sh; b8.i_ser_in = tbl[i].sin; b8.i_par_in = tbl[i].par;
         tick();
         check($sformatf("tbl%0d_par", i),  b8.o_par_out, tbl[i].e_par);
         check($sformatf("tbl%0d_so", i),   b8.o_ser_out, tbl[i].e_so);
         check($sformatf("tbl%0d_busy", i), b8.o_busy, tbl[i].e_busy);
         check($sformatf("tbl%0d_done", i), b8.o_done, tbl[i].e_done);
         check($sformatf("tbl%0d_cnt", i),  b8.o_cnt, tbl[i].e_cnt);
      end
      b8.i_load = 0; b8.i_start = 0; b8.i_shift_en = 0; b8.i_ser_in = 0;

      // Asynchronous reset in the middle of an operation.
      b8.i_load = 1; b8.i_par_in = 8'hA5; tick(); b8.i_load = 0;
      b8.i_start = 1; tick(); b8.i_start = 0;
      b8.i_shift_en = 1; b8.i_ser_in = 0;
      repeat (3) tick();
      b8.i_shift_en = 0;
      check("rstmid_pre_cnt", b8.o_cnt, 3);
      check("rstmid_pre_par", b8.o_par_out, 8'h14);
      #3 i_rst = 1'b1;
      #1;
      check("rstmid_par",  b8.o_par_out, 0);
      check("rstmid_busy", b8.o_busy, 0);
      check("rstmid_cnt",  b8.o_cnt, 0);
      check("rstmid_so",   b8.o_ser_out, 0);
      #1 i_rst = 1'b0;
      tick();

      // Stall for three cycles after two shifts.
      b8.i_load = 1; b8.i_par_in = 8'h0F; tick(); b8.i_load = 0;
      b8.i_start = 1; q8.push_back(8'hFF); tick(); b8.i_start = 0;
      b8.i_shift_en = 1; b8.i_ser_in = 1;
      repeat (2) tick();
      b8.i_shift_en = 0;
      check("stall_pre_par", b8.o_par_out, 8'hC3);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stall%0d_par", k),  b8.o_par_out, 8'hC3);
         check($sformatf("stall%0d_so", k),   b8.o_ser_out, 1);
         check($sformatf("stall%0d_cnt", k),  b8.o_cnt, 2);
         check($sformatf("stall%0d_busy", k), b8.o_busy, 1);
      end
      run8(1'b1, 20, cyc);
      check("stall_latency", 5 + cyc, 11);
      tick();

      // Load/start ignored while shifting, then clear aborts.
      b8.i_load = 1; b8.i_par_in = 8'h55; tick(); b8.i_load = 0;
      b8.i_start = 1; tick(); b8.i_start = 0;
      b8.i_shift_en = 1; b8.i_ser_in = 0;
      repeat (2) tick();
      check("prio_pre_par", b8.o_par_out, 8'h15);
      b8.i_load = 1; b8.i_par_in = 8'hFF; b8.i_start = 1;
      tick();
      check("prio_load_ign", b8.o_par_out, 8'h0A);
      check("prio_start_ign", b8.o_cnt, 3);
      check("prio_busy", b8.o_busy, 1);
      b8.i_start = 0; b8.i_shift_en = 0; b8.i_clr = 1;
      tick();
      b8.i_clr = 0; b8.i_load = 0;
      check("clr_par",  b8.o_par_out, 0);
      check("clr_busy", b8.o_busy, 0);
      check("clr_cnt",  b8.o_cnt, 0);
      check("clr_done", b8.o_done, 0);
      repeat (12) tick();
      check("clr_idle", b8.o_busy, 0);

      // Simultaneous load+start, then back-to-back start in the done cycle.
      b8.i_load = 1; b8.i_par_in = 8'h81; b8.i_start = 1; q8.push_back(8'hFF);
      tick();
      b8.i_load = 0; b8.i_start = 0;
      check("sim_busy", b8.o_busy, 1);
      check("sim_so",   b8.o_ser_out, 1);
      check("sim_par",  b8.o_par_out, 8'h81);
      run8(1'b1, 20, cyc);
      check("sim_latency", cyc, 8);
      check("b2b_busy_done", b8.o_busy, 0);
      b8.i_start = 1; q8.push_back(8'h00);
      tick();
      b8.i_start = 0;
      check("b2b_busy_again", b8.o_busy, 1);
      check("b2b_cnt", b8.o_cnt, 0);
      run8(1'b0, 20, cyc);
      check("b2b_latency", cyc, 8);
      tick();
      check("b2b_done_pulse", b8.o_done, 0);

      // MSB-first, N=12.
      b12.i_load = 1; b12.i_par_in = 12'h801; tick(); b12.i_load = 0;
      b12.i_start = 1; q12.push_back(12'h000); tick(); b12.i_start = 0;
      b12.i_shift_en = 1; b12.i_ser_in = 0;
      for (int k = 0; k < 12; k++) begin
         check($sformatf("msb%0d_so", k),  b12.o_ser_out, (k == 0 || k == 11) ? 1 : 0);
         check($sformatf("msb%0d_cnt", k), b12.o_cnt, k);
         tick();
      end
      b12.i_shift_en = 0;
      check("msb_done", b12.o_done, 1);
      check("msb_busy", b12.o_busy, 0);
      check("msb_cnt",  b12.o_cnt, 0);

      repeat (3) tick();
      check("q8_drained",  q8.size(), 0);
      check("q12_drained", q12.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
